// File: rtl/i2s_encoder.sv
// Free-running Philips I2S transmitter: divides clk into LRCLK and BCLK and
// shifts out one coherent 16-bit left/right sample pair per frame, MSB-first.
module i2s_encoder #(
    parameter logic [9:0] LRCLK_DIV = 10'd511,
    parameter logic [3:0] BCLK_DIV  = 4'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] r_chan_i,
    input  logic [15:0] l_chan_i,
    output logic        lrclk_o,
    output logic        bclk_o,
    output logic        dacdat_o
);

    localparam logic [10:0] FRAME_LEN = {1'b0, LRCLK_DIV} + 11'd1;
    localparam logic [9:0]  HALF_LEN  = FRAME_LEN[10:1];
    localparam logic [4:0]  BCLK_LEN  = {1'b0, BCLK_DIV} + 5'd1;
    localparam logic [3:0]  BCLK_HALF = BCLK_LEN[4:1];

    logic [9:0]  fc_q, fc_d;
    logic [3:0]  bc_q, bc_d;
    logic [9:0]  slot_q, slot_d;
    logic [15:0] lhold_q, rhold_q;
    logic        lrclk_q, lrclk_d;
    logic        bclk_q, bclk_d;
    logic        dacdat_q, dacdat_d;

    logic [15:0] hold_sel;
    logic [3:0]  bit_idx;

    // Counter next state; slot realigns at both half-frame boundaries.
    always_comb begin
        fc_d   = (fc_q == LRCLK_DIV) ? 10'd0 : fc_q + 10'd1;
        bc_d   = (bc_q == BCLK_DIV) ? 4'd0 : bc_q + 4'd1;
        slot_d = slot_q;
        if (fc_d == 10'd0 || fc_d == HALF_LEN) begin
            slot_d = 10'd0;
        end else if (bc_q == BCLK_DIV) begin
            slot_d = slot_q + 10'd1;
        end
    end

    // Outputs decode the current counter state and are registered below,
    // which gives the fixed one-clk lag; slot 0 is the I2S one-bit delay.
    always_comb begin
        lrclk_d  = (fc_q >= HALF_LEN);
        bclk_d   = (bc_q >= BCLK_HALF);
        hold_sel = lrclk_d ? rhold_q : lhold_q;
        bit_idx  = 4'(5'd16 - slot_q[4:0]);
        dacdat_d = 1'b0;
        if (slot_q != 10'd0 && slot_q <= 10'd16) begin
            dacdat_d = hold_sel[bit_idx];
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            fc_q     <= '0;
            bc_q     <= '0;
            slot_q   <= '0;
            lhold_q  <= '0;
            rhold_q  <= '0;
            lrclk_q  <= 1'b0;
            bclk_q   <= 1'b0;
            dacdat_q <= 1'b0;
        end else begin
            fc_q     <= fc_d;
            bc_q     <= bc_d;
            slot_q   <= slot_d;
            lrclk_q  <= lrclk_d;
            bclk_q   <= bclk_d;
            dacdat_q <= dacdat_d;
            // Both channels latch on the same edge so the pair stays coherent.
            if (fc_q == 10'd0) begin
                lhold_q <= l_chan_i;
                rhold_q <= r_chan_i;
            end
        end
    end

    assign lrclk_o  = lrclk_q;
    assign bclk_o   = bclk_q;
    assign dacdat_o = dacdat_q;

endmodule

// File: tb/tb_i2s_encoder.sv
// Directed bench for i2s_encoder: default divider instance plus a
// LRCLK_DIV=255 / BCLK_DIV=1 instance, decoded from the serial outputs.
module tb_i2s_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] l_chan;
    logic [15:0] r_chan;
    logic        lr1, bc1, dd1;
    logic        lr2, bc2, dd2;
    logic        sel;
    logic        lr_s, bclk_s, dd_s;
    logic        prev_bclk;
    logic        prev_lr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    i2s_encoder dut (
        .clk      (clk),
        .rst      (rst),
        .r_chan_i (r_chan),
        .l_chan_i (l_chan),
        .lrclk_o  (lr1),
        .bclk_o   (bc1),
        .dacdat_o (dd1)
    );

    i2s_encoder #(
        .LRCLK_DIV (10'd255),
        .BCLK_DIV  (4'd1)
    ) dut2 (
        .clk      (clk),
        .rst      (rst),
        .r_chan_i (r_chan),
        .l_chan_i (l_chan),
        .lrclk_o  (lr2),
        .bclk_o   (bc2),
        .dacdat_o (dd2)
    );

    assign lr_s   = sel ? lr2 : lr1;
    assign bclk_s = sel ? bc2 : bc1;
    assign dd_s   = sel ? dd2 : dd1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling clk edge, remembering the previous sample.
    task automatic tick();
        prev_bclk = bclk_s;
        prev_lr   = lr_s;
        @(negedge clk);
    endtask

    // Starting at the first sample of an LRCLK half, decode it until LRCLK
    // toggles; optionally change l_chan at sample number chg_at.
    task automatic capture_half(input logic level, input int chg_at, input logic [15:0] chg_val,
                                output int len, output int rises, output int pad_bad,
                                output logic [15:0] word);
        len     = 0;
        rises   = 0;
        pad_bad = 0;
        word    = '0;
        while (lr_s === level && len < 3000) begin
            len++;
            if (chg_at == len) l_chan = chg_val;
            if (bclk_s === 1'b1 && prev_bclk === 1'b0) begin
                rises++;
                if (rises >= 2 && rises <= 17) word[17 - rises] = dd_s;
                else if (dd_s !== 1'b0) pad_bad++;
            end
            tick();
        end
    endtask

    task automatic do_half(input string tag, input logic level, input int chg_at,
                           input logic [15:0] chg_val, input int exp_len, input logic [15:0] exp_word);
        int len, rises, pad_bad;
        logic [15:0] word;
        capture_half(level, chg_at, chg_val, len, rises, pad_bad, word);
        check($sformatf("%s_len", tag), len, exp_len);
        check($sformatf("%s_rises", tag), rises, 64);
        check($sformatf("%s_pad", tag), pad_bad, 0);
        check($sformatf("%s_word", tag), {16'h0, word}, {16'h0, exp_word});
    endtask

    task automatic bclk_meas(output int per, output int high);
        int n;
        n    = 0;
        per  = 0;
        high = 0;
        while (!(bclk_s === 1'b1 && prev_bclk === 1'b0) && n < 100) begin
            tick();
            n++;
        end
        high = 1;
        n    = 0;
        while (n < 100) begin
            tick();
            n++;
            per++;
            if (bclk_s === 1'b1 && prev_bclk === 1'b0) break;
            if (bclk_s === 1'b1) high++;
        end
    endtask

    initial begin
        int bad, per, high, n;
        sel    = 1'b0;
        rst    = 1'b1;
        l_chan = 16'h0034;
        r_chan = 16'h0012;

        bad = 0;
        repeat (10) begin
            tick();
            if ({lr1, bc1, dd1, lr2, bc2, dd2} !== 6'b0) bad++;
        end
        check("reset_hold", bad, 0);

        rst = 1'b0;
        tick();
        for (int f = 0; f < 4; f++) begin
            do_half($sformatf("f%0d_left", f), 1'b0, 0, 16'h0, 256, 16'h0034);
            do_half($sformatf("f%0d_right", f), 1'b1, 0, 16'h0, 256, 16'h0012);
        end

        do_half("coh_left_old", 1'b0, 100, 16'h8001, 256, 16'h0034);
        do_half("coh_right", 1'b1, 0, 16'h0, 256, 16'h0012);
        do_half("coh_left_new", 1'b0, 0, 16'h0, 256, 16'h8001);

        // Now at the start of the right half: move into its data slots, then reset.
        repeat (24) tick();
        check("midrst_in_right", {31'h0, lr1}, 32'h1);
        rst = 1'b1;
        bad = 0;
        repeat (3) begin
            tick();
            if ({lr1, bc1, dd1} !== 3'b0) bad++;
        end
        check("midrst_zero", bad, 0);
        rst = 1'b0;
        tick();
        do_half("post_rst_left", 1'b0, 0, 16'h0, 256, 16'h8001);
        do_half("post_rst_right", 1'b1, 0, 16'h0, 256, 16'h0012);

        bclk_meas(per, high);
        check("bclk_period", per, 4);
        check("bclk_high", high, 2);

        sel    = 1'b1;
        l_chan = 16'hA5C3;
        r_chan = 16'h7E01;
        tick();
        n = 0;
        while (!(lr_s === 1'b0 && prev_lr === 1'b1) && n < 3000) begin
            tick();
            n++;
        end
        check("d2_found_frame", {31'h0, n < 3000}, 32'h1);
        do_half("d2_left", 1'b0, 0, 16'h0, 128, 16'hA5C3);
        do_half("d2_right", 1'b1, 0, 16'h0, 128, 16'h7E01);
        bclk_meas(per, high);
        check("d2_bclk_period", per, 2);
        check("d2_bclk_high", high, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2s_encoder.md
Name: i2s_encoder

Overview:
- Free-running I2S transmitter. Serialises one 16-bit left and one 16-bit right sample per frame.
- Generates LRCLK, BCLK and serial data from a single system clock using integer dividers.
- Used as the audio-source model feeding the aura FPGA's VERA audio input (VAUDIO_LRCK/BCK/DATA), and as a generic DAC-side I2S encoder.
- Standard Philips I2S framing: MSB-first, one-BCLK delay after each LRCLK edge, left channel while LRCLK is low.

Parameters:
- LRCLK_DIV, 10'd511: frame length minus 1, in clk cycles. F = LRCLK_DIV+1; default gives 512 cycles, i.e. 48.828 kHz at 25 MHz.
- BCLK_DIV, 4'd3: BCLK period minus 1, in clk cycles. P = BCLK_DIV+1; default gives 4 cycles, i.e. 6.25 MHz.
- Legal settings:
  - F even; P even.
  - H = F/2 must be a multiple of P.
  - H/P ≥ 17 BCLK slots per half-frame.
  - Other values are unsupported; no checking is required.

Ports:
- clk, input, 1: system clock (25 MHz nominal).
- rst, input, 1: synchronous reset, active-high.
- r_chan_i, input, 16: right-channel sample, two's complement.
- l_chan_i, input, 16: left-channel sample, two's complement.
- lrclk_o, output, 1: word select; 0 = left, 1 = right.
- bclk_o, output, 1: bit clock.
- dacdat_o, output, 1: serial data, MSB-first.

Behaviour:
- State registers:
  - fc: frame counter, 0..F-1.
  - bc: BCLK phase, 0..P-1.
  - slot: bit-slot index within the half-frame, 0..H/P-1.
  - lhold, rhold: 16-bit sample holding registers.
- Reset: while rst is high at a clk edge, fc=bc=slot=0, lhold=rhold=0, lrclk_o=0, bclk_o=0, dacdat_o=0. Reset mid-frame aborts the frame immediately; there is no flush or completion.
- Counting (rst low, every clk):
  - fc increments and wraps F-1→0.
  - bc increments and wraps P-1→0.
  - slot increments when bc wraps.
  - slot returns to 0 when fc wraps to 0 and when fc reaches H.
- Sample capture: on the edge where fc==0 (rst low), lhold←l_chan_i and rhold←r_chan_i together, so the pair stays coherent. Input changes at any other time do not affect the current frame.
- Outputs are registered and lag the counter state by exactly one clk. In the cycle after the counter state was v:
  - lrclk_o = (fc ≥ H).
  - bclk_o = (bc ≥ P/2): low for the first half of each BCLK period, high for the second. Data therefore changes on BCLK falling edges and is stable at rising edges.
  - dacdat_o:
    - slot 0 → 0 (I2S one-bit delay).
    - slot k with 1≤k≤16 → hold[16-k], where hold = lhold when lrclk_o=0, else rhold.
    - slot > 16 → 0 (zero padding).
- Defaults give 64 BCLKs per channel: 1 delay slot, 16 data slots, 47 zero slots.
- The first frame after reset release starts immediately. lrclk_o stays 0 for H cycles, except for the one-cycle output lag.
- No handshake: inputs are sampled blindly once per frame.

Test Plan:
- Reset hold: rst=1 for 10 cycles, inputs nonzero -> lrclk_o=bclk_o=dacdat_o=0 throughout.
- Clock ratios (defaults): release rst, measure over 4 frames -> lrclk_o period 512 clk (256 low, 256 high); bclk_o period 4 clk (2 low, 2 high); exactly 64 bclk rising edges per LRCLK half.
- Data pattern: l_chan_i=16'h0034, r_chan_i=16'h0012 -> at bclk rising edges 2..17 after lrclk_o falls, serial data = 0000000000110100; after lrclk_o rises, 0000000000010010. Edge 1 and edges 18..64 sample 0.
- Capture coherence: change l_chan_i from 16'h0034 to 16'h8001 at fc=100 -> current frame still sends 0x0034; the next frame sends 1000000000000001.
- Mid-frame reset: assert rst during a right-channel data slot, hold 3 cycles, release -> outputs 0 during reset. A fresh frame then starts with lrclk_o=0 and left data beginning at the second BCLK.
- Non-default parameters: LRCLK_DIV=255, BCLK_DIV=1 -> lrclk_o period 256 clk, bclk_o period 2 clk, 64 slots per half. MSB again appears in slot 1.
